// File: rtl/seq_gen_pattern_tx_if.sv
// ----------------------------------------------------------------------------
// seq_gen_pattern_tx_if
//   Request/serial-output bundle for the serial pattern generator.
//   master : the requester (drives start/pattern/len/rep, watches the line)
//   slave  : the generator (seq_gen_pattern_tx)
// Signals
//   start    request pulse, sampled by the generator only while idle
//   pattern  bits to send, pattern[len-1] first
//   len      bits per frame (0 or >PAT_W means PAT_W)
//   rep      extra repetitions, frames sent = rep+1
//   d_out    serial data, 0 whenever valid=0
//   valid    d_out carries a pattern bit
//   busy     generator is shifting or finishing
//   done     one-cycle pulse after the last bit of the last frame
// ----------------------------------------------------------------------------
interface seq_gen_pattern_tx_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] rep;
  logic             d_out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, rep,
    input  d_out, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, rep,
    output d_out, valid, busy, done
  );
endinterface

// File: rtl/seq_gen_pattern_tx.sv
// ----------------------------------------------------------------------------
// seq_gen_pattern_tx
//   Serial pattern generator. On start (while idle) it captures a pattern, its
//   effective length L and a repeat count, then shifts the pattern out MSB-first
//   (pattern[L-1] first) one bit per clock. Frames repeat back-to-back with no
//   idle bit, rep+1 frames in total, followed by a single-cycle done pulse.
//   Moore FSM; all outputs come straight from flops.
// Ports
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  seq_gen_pattern_tx_if.slave (start/pattern/len/rep in,
//        d_out/valid/busy/done out)
// ----------------------------------------------------------------------------
module seq_gen_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_gen_pattern_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [PAT_W-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  logic             d_out_d, valid_d, busy_d, done_d;
  logic [LEN_W-1:0] eff_len;
  logic [PAT_W-1:0] start_shift;
  logic [PAT_W-1:0] reload_shift;

  // Out-of-range lengths collapse to the full pattern width.
  assign eff_len = ((bus.len == '0) || (bus.len > FULL_LEN)) ? FULL_LEN : bus.len;

  // Left-align so that bit L-1 of the pattern lands on the MSB.
  assign start_shift  = bus.pattern << (FULL_LEN - eff_len);
  assign reload_shift = pat_q << (FULL_LEN - len_q);

  // NOTE: every signal this block writes gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pat_d     = bus.pattern;
          len_d     = eff_len;
          rep_cnt_d = bus.rep;
          shift_d   = start_shift;
          bit_cnt_d = eff_len - LEN_W'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end else if (rep_cnt_q != '0) begin
          // Next frame starts on the very next cycle: no gap bit.
          shift_d   = reload_shift;
          bit_cnt_d = len_q - LEN_W'(1);
          rep_cnt_d = rep_cnt_q - REP_W'(1);
        end else begin
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered and
    // still line up with the state they describe.
    valid_d = (state_d == ST_SHIFT);
    d_out_d = valid_d & shift_d[PAT_W-1];
    busy_d  = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the captured pattern/len copies are cleared too; they are small
      // flop registers, not a RAM, so resetting them costs nothing special.
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      bus.d_out <= 1'b0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      bus.d_out <= d_out_d;
      bus.valid <= valid_d;
      bus.busy  <= busy_d;
      bus.done  <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_gen_pattern_tx.sv
// ----------------------------------------------------------------------------
// tb_seq_gen_pattern_tx
//   Self-checking bench for seq_gen_pattern_tx. Expected bit streams come from
//   a frame-level model: the bit list pattern[L-1..0] repeated rep+1 times.
//   Outputs are sampled on the falling edge; inputs change on the falling edge.
// ----------------------------------------------------------------------------
module tb_seq_gen_pattern_tx;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_gen_pattern_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

  seq_gen_pattern_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  logic exp_q[$];
  int   det_hits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference bit stream for one request.
  task automatic build_exp(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic [REP_W-1:0] rep);
    int l;
    l = (len == 0 || int'(len) > PAT_W) ? PAT_W : int'(len);
    exp_q.delete();
    for (int f = 0; f <= int'(rep); f++)
      for (int b = l - 1; b >= 0; b--)
        exp_q.push_back(pat[b]);
  endtask

  function automatic logic [3:0] outs();
    return {bus.d_out, bus.valid, bus.busy, bus.done};
  endfunction

  // One full transaction: start, every bit, done pulse, return to idle.
  // With noisy=1, start and the data inputs are scrambled after capture.
  task automatic run_tx(input string tag, input logic [PAT_W-1:0] pat,
                        input logic [LEN_W-1:0] len, input logic [REP_W-1:0] rep,
                        input logic noisy);
    int run;
    build_exp(pat, len, rep);
    det_hits = 0;
    run      = 0;
    @(negedge clk);
    bus.pattern = pat;
    bus.len     = len;
    bus.rep     = rep;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s bit%0d", tag, i), 32'(outs()), {28'd0, exp_q[i], 3'b110});
      // Stand-in "111" detector listening on the line.
      run = (bus.valid && bus.d_out) ? run + 1 : 0;
      if (run >= 3) det_hits++;
      if (noisy) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.pattern = PAT_W'($urandom);
        bus.len     = LEN_W'($urandom);
        bus.rep     = REP_W'($urandom);
      end
      @(negedge clk);
    end
    check($sformatf("%s done", tag), 32'(outs()), 32'b0011);
    bus.start = noisy;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("%s idle", tag), 32'(outs()), 32'b0000);
  endtask

  initial begin
    logic seen_done;
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.len     = 4'd3;
    bus.rep     = 4'd0;

    // 1. Reset dominates start.
    repeat (2) begin
      @(negedge clk);
      check("reset outs", 32'(outs()), 32'b0000);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("post-reset idle", 32'(outs()), 32'b0000);

    // 2..4. Directed frames.
    run_tx("p07_l3_r0", 8'h07, 4'd3, 4'd0, 1'b0);
    run_tx("p05_l3_r2", 8'h05, 4'd3, 4'd2, 1'b0);
    run_tx("pA5_l0_r0", 8'hA5, 4'd0, 4'd0, 1'b1);
    run_tx("p02_l1_r3", 8'h02, 4'd1, 4'd3, 1'b0);
    run_tx("p96_l12_r1", 8'h96, 4'd12, 4'd1, 1'b0);

    // 6. Loopback into a 111 detector: overlap keeps it high for 4 cycles.
    run_tx("loop111", 8'h07, 4'd3, 4'd1, 1'b0);
    check("loop111 det cycles", 32'(det_hits), 32'd4);

    // 5. Abort with reset on the 5th valid bit.
    @(negedge clk);
    bus.pattern = 8'hFF;
    bus.len     = 4'd8;
    bus.rep     = 4'd3;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort bit%0d", i), 32'(outs()), 32'b1110);
      if (i < 4) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort outs", 32'(outs()), 32'b0000);
    rst       = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.valid) seen_done = 1'b1;
    end
    check("abort no done", 32'(seen_done), 32'd0);

    // Randomized requests against the frame model.
    for (int t = 0; t < 25; t++) begin
      run_tx($sformatf("rnd%0d", t), PAT_W'($urandom), LEN_W'($urandom),
             REP_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
